// File: rtl/btb_alloc_ctrl.sv
// BTB allocation / replacement controller.
// Chooses the entry written by each branch-resolution update (hit in place,
// lowest free entry, or LFSR victim), tracks per-entry valid bits and runs a
// one-entry-per-cycle invalidate sweep on flush.
module btb_alloc_ctrl #(
    parameter int          DEPTH     = 32,
    parameter int          ADDR_W    = 5,
    parameter logic [15:0] LFSR_INIT = 16'h0001,
    parameter logic [15:0] LFSR_TAP  = 16'hB400
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              upd_valid_i,
    output logic              upd_ready_o,
    input  logic              upd_hit_i,
    input  logic [ADDR_W-1:0] upd_hit_entry_i,
    input  logic              flush_i,
    output logic              flush_busy_o,
    output logic              wr_valid_o,
    output logic [ADDR_W-1:0] wr_entry_o,
    output logic              wr_alloc_o,
    output logic              wr_evict_o,
    output logic              inv_valid_o,
    output logic [ADDR_W-1:0] inv_entry_o,
    output logic [DEPTH-1:0]  valid_vec_o
);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  sweep_q;
    logic [DEPTH-1:0]   valid_q;
    logic [15:0]        lfsr_q;
    logic [15:0]        lfsr_step;
    logic               accept;
    logic               table_full;
    logic [ADDR_W-1:0]  free_idx;
    logic [ADDR_W-1:0]  sel_entry;
    logic               evict;

    assign upd_ready_o  = (state_q == IDLE) && !flush_i;
    assign accept       = upd_valid_i && upd_ready_o;
    assign table_full   = &valid_q;
    assign evict        = !upd_hit_i && table_full;
    assign flush_busy_o = (state_q == FLUSH);
    assign inv_valid_o  = (state_q == FLUSH);
    assign inv_entry_o  = sweep_q;
    assign valid_vec_o  = valid_q;
    assign lfsr_step    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAP : 16'h0000);

    // Priority-encode the lowest-index invalid entry (descending scan, last write wins).
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = i[ADDR_W-1:0];
        end
    end

    // Entry selection: hit entry, else lowest free, else LFSR victim.
    always_comb begin
        sel_entry = upd_hit_entry_i;
        if (!upd_hit_i) sel_entry = table_full ? lfsr_q[ADDR_W-1:0] : free_idx;
    end

    // Next-state: a flush request in IDLE starts the sweep; sweep ends after the last entry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (flush_i) state_d = FLUSH;
            FLUSH:   if (sweep_q == ADDR_W'(DEPTH - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, sweep index, valid bits and LFSR.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sweep_q <= '0;
            valid_q <= '0;
            lfsr_q  <= LFSR_INIT;
        end else begin
            state_q <= state_d;
            if (state_q == FLUSH) begin
                // Wraps to 0 after the last entry since DEPTH == 2**ADDR_W.
                sweep_q          <= sweep_q + 1'b1;
                valid_q[sweep_q] <= 1'b0;
            end else if (accept) begin
                valid_q[sel_entry] <= 1'b1;
                if (evict) lfsr_q <= lfsr_step;
            end
        end
    end

    // Registered write strobe and attributes, one-cycle pulse per accept.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_valid_o <= 1'b0;
            wr_entry_o <= '0;
            wr_alloc_o <= 1'b0;
            wr_evict_o <= 1'b0;
        end else begin
            wr_valid_o <= accept;
            wr_entry_o <= accept ? sel_entry : '0;
            wr_alloc_o <= accept && !upd_hit_i;
            wr_evict_o <= accept && evict;
        end
    end

endmodule
